count_snap_fifo: RTL
====================

// Module: count_snap_fifo
// PURPOSE
//  Downstream consumer of the counter stage.
//  - Snapshots the counter's count value each cycle the capture strobe is high.
//  - Buffers snapshots in a DEPTH-entry FIFO.
//  - Hands them to a checker/host over a valid/ready handshake.
//  - Flags snapshots lost to a full buffer.
//  Connects to the same interface bundle as the counter: shared clk/rst_n, count bus.
// PARAMETERS
//  WIDTH  4  width of captured count; equals counter width
//  DEPTH  4  FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1                  system clock, all logic on rising edge
//  rst_n       in   1                  reset, synchronous, active-low
//  count_in    in   WIDTH              counter output value
//  cap_i       in   1                  capture strobe: push count_in this cycle
//  snap_data   out  WIDTH              head-of-FIFO snapshot
//  snap_valid  out  1                  head entry valid
//  snap_ready  in   1                  consumer accepts head this cycle
//  full        out  1                  DEPTH entries held
//  empty       out  1                  zero entries held
//  level       out  $clog2(DEPTH)+1    entries held, 0..DEPTH
//  overflow    out  1                  sticky: a capture was dropped
//  clr_ovf     in   1                  clears overflow
// BEHAVIOUR
//  - Reset (rst_n=0 at edge):
//    - Pointers, level and overflow go to 0; empty=1; full=0; snap_valid=0; snap_data=0.
//    - Stored contents are discarded.
//    - A reset asserted mid-stream drops all pending snapshots; cap_i is ignored that cycle.
//  - Pointers: wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//    - empty = (wr_ptr == rd_ptr).
//    - full  = MSBs differ and low bits are equal.
//  - push = cap_i && (!full || pop). pop = snap_valid && snap_ready.
//  - Capture latency: count_in sampled at edge k.
//    - If empty before edge k, snap_valid=1 and snap_data=count_in(k) after edge k (1 cycle).
//  - Read side is first-word-fall-through:
//    - snap_data = mem[rd_ptr] while !empty; forced to 0 when empty.
//    - snap_valid = !empty.
//  - Handshake:
//    - snap_data is held stable while snap_valid && !snap_ready.
//    - An entry retires only on pop.
//  - Simultaneous events:
//    - push && pop: level unchanged, both pointers advance.
//    - Full with cap_i && pop: the capture is accepted (no drop).
//    - Empty with cap_i && snap_ready: push only; no pop since snap_valid=0.
//  - Overflow:
//    - cap_i && full && !pop: snapshot dropped, overflow=1 from the next edge.
//    - clr_ovf clears overflow at the edge.
//    - New drop and clr_ovf in the same cycle: set wins.
//  - level = wr_ptr - rd_ptr (modulo arithmetic); it never exceeds DEPTH.
//  - All outputs are registered or derived from registered pointers.
//    - No combinational path from cap_i/count_in to outputs.
// CONFIGURATION
//  SNAP_DROP_CNT_EN defined:
//    - Adds output drop_cnt [7:0]: number of dropped captures.
//    - Saturates at 255; reset to 0.
//    - Cleared by clr_ovf unless a drop occurs the same cycle, in which case it loads 1.
//  SNAP_DROP_CNT_EN undefined:
//    - drop_cnt port and its logic are absent.
//    - overflow behaviour is unchanged.
// STRUCTURE
//  - Shared package count_pkg:
//    - COUNT_W constant (default 4), feeding WIDTH here and the counter.
//    - typedef logic [COUNT_W-1:0] count_t.
//    - DROP_CNT_W = 8.
//  - Sub-module snap_fifo_mem: DEPTH x WIDTH register array.
//    - Synchronous write port; asynchronous read port.
//  - Top module owns pointers, flags, overflow and the optional drop counter.
// TESTING
//  1. Reset, no cap_i for 10 cycles -> empty=1, level=0, snap_valid=0, snap_data=0, overflow=0.
//  2. cap_i one cycle at count_in=4'h3, snap_ready=0
//     -> snap_valid=1, snap_data=3 next cycle; held for 5 cycles; snap_ready=1 -> empty next cycle.
//  3. cap_i 4 consecutive cycles with counts 5,6,7,8, no ready
//     -> full=1, level=4; then drain with ready=1 -> 5,6,7,8 in order.
//  4. Full, cap_i=1 with snap_ready=0
//     -> overflow=1, level stays 4; drop_cnt=1 when macro on.
//     Repeat with snap_ready=1 -> no drop, level stays 4.
//  5. overflow=1, clr_ovf and new drop same cycle -> overflow remains 1.
//     clr_ovf alone -> overflow=0.
//  6. Counter wrapping 15->0 captured continuously with ready=1, then rst_n=0 mid-stream
//     -> data 14,15,0,1 in order; after reset empty=1, old entries never appear.

Source files
------------

// File: rtl/count_pkg.sv
// Shared definitions for the counter stage and its snapshot FIFO consumer.
// Count width, the count value type and the optional drop-counter width.
package count_pkg;

    localparam int COUNT_W    = 4;
    localparam int DROP_CNT_W = 8;

    typedef logic [COUNT_W-1:0] count_t;

    // Saturating increment for the drop counter: sticks at all-ones.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/snap_fifo_mem.sv
// DEPTH x WIDTH snapshot storage: one synchronous write port and one
// asynchronous read port so the FIFO head is presented without extra latency.
module snap_fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents carry no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/count_snap_fifo.sv
// Snapshots count_in on cap_i into a first-word-fall-through FIFO with a sticky
// overflow flag. Define SNAP_DROP_CNT_EN to add the saturating drop_cnt output.
module count_snap_fifo
    import count_pkg::*;
#(
    parameter int WIDTH = COUNT_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     cap_i,
    output logic [WIDTH-1:0]         snap_data,
    output logic                     snap_valid,
    input  logic                     snap_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     clr_ovf
`ifdef SNAP_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]    drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic             empty_w, full_w;
    logic             push, pop, drop;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_rd_data;

    // One extra pointer bit distinguishes a full buffer from an empty one.
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign pop  = !empty_w && snap_ready;
    assign push = cap_i && (!full_w || pop);
    assign drop = cap_i && full_w && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // A capture coinciding with reset must not land in storage.
    assign mem_wr_en = push && rst_n;

    snap_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (count_in),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (mem_rd_data)
    );

    assign snap_data  = empty_w ? '0 : mem_rd_data;
    assign snap_valid = !empty_w;
    assign empty      = empty_w;
    assign full       = full_w;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;

`ifdef SNAP_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A drop in the clearing cycle restarts the count at one rather than zero.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && clr_ovf) begin
            drop_cnt_d = DROP_CNT_W'(1);
        end else if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end else if (clr_ovf) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule
